// File: rtl/branch_resolve_pkg.sv
// Shared types and helpers for the branch resolve unit: funct3 codes,
// BHT counter encoding, FSM states and the saturating counter update.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_t;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } br_state_t;

  function automatic bht_cnt_t sat_update(bht_cnt_t cnt, logic taken);
    bht_cnt_t res;
    res = cnt;
    if (taken) begin
      if (cnt != ST) res = bht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) res = bht_cnt_t'(cnt - 2'd1);
    end
    return res;
  endfunction

  // 010 and 011 are the only encodings with no conditional branch behind them.
  function automatic logic f3_legal(logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bundle of prediction, resolution and comparator signals around branch_resolve.
interface branch_resolve_if #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 32
);

  logic                 Ready;
  logic [DWIDTH-1:0]    Pred_PC;
  logic                 Pred_Taken;
  logic                 Res_Valid;
  logic [DWIDTH-1:0]    Res_PC;
  logic [2:0]           Res_Funct3;
  logic                 Res_Pred_Taken;
  logic                 Branch_Un_Ctrl;
  logic                 Branch_Equal;
  logic                 Branch_Lt;
  logic                 Branch_Taken;
  logic                 Mispredict;
  logic [CNT_WIDTH-1:0] Branch_Count;
  logic [CNT_WIDTH-1:0] Mispredict_Count;

  modport slave (
    input  Pred_PC, Res_Valid, Res_PC, Res_Funct3, Res_Pred_Taken,
           Branch_Equal, Branch_Lt,
    output Ready, Pred_Taken, Branch_Un_Ctrl, Branch_Taken, Mispredict,
           Branch_Count, Mispredict_Count
  );

  modport master (
    output Pred_PC, Res_Valid, Res_PC, Res_Funct3, Res_Pred_Taken,
           Branch_Equal, Branch_Lt,
    input  Ready, Pred_Taken, Branch_Un_Ctrl, Branch_Taken, Mispredict,
           Branch_Count, Mispredict_Count
  );

endinterface

// File: rtl/branch_resolve_hist_table.sv
// 2-bit saturating branch history table with a post-reset sweep that sets
// every entry to weakly-not-taken before reporting ready.
module branch_hist_table
  import branch_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_cnt_t         rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  output logic             ready
);

  br_state_t        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  bht_cnt_t         bht_q [BHT_DEPTH];
  bht_cnt_t         bht_d [BHT_DEPTH];

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    bht_d      = bht_q;
    case (state_q)
      S_INIT: begin
        bht_d[init_idx_q] = WNT;
        init_idx_d        = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(BHT_DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (wr_en) bht_d[wr_idx] = sat_update(bht_q[wr_idx], wr_taken);
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Table contents are never reset; the init sweep rebuilds them.
  always_ff @(posedge Clk) begin
    bht_q <= bht_d;
  end

  // Asynchronous read sees the pre-edge value on a same-index write.
  assign rd_cnt = bht_q[rd_idx];
  assign ready  = (state_q == S_RUN);

endmodule

// File: rtl/branch_resolve.sv
// Resolves conditional branches from comparator flags, trains the BHT,
// flags mispredictions and counts branches and mispredicts.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  branch_resolve_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0]     pred_idx;
  logic [IDX_W-1:0]     res_idx;
  bht_cnt_t             pred_cnt;
  logic                 ready;
  logic                 taken;
  logic                 legal;
  logic                 upd;
  logic                 misp;
  logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;
  logic                 unused_pc_bits;

  assign pred_idx       = bus.Pred_PC[IDX_W+1:2];
  assign res_idx        = bus.Res_PC[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.Pred_PC, bus.Res_PC};

  branch_hist_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_bht (
    .Clk      (Clk),
    .Reset    (Reset),
    .rd_idx   (pred_idx),
    .rd_cnt   (pred_cnt),
    .wr_en    (upd),
    .wr_idx   (res_idx),
    .wr_taken (taken),
    .ready    (ready)
  );

  always_comb begin
    taken = 1'b0;
    case (bus.Res_Funct3)
      F3_BEQ:           taken = bus.Branch_Equal;
      F3_BNE:           taken = !bus.Branch_Equal;
      F3_BLT, F3_BLTU:  taken = bus.Branch_Lt;
      F3_BGE, F3_BGEU:  taken = !bus.Branch_Lt;
      default:          taken = 1'b0;
    endcase
  end

  always_comb begin
    legal    = f3_legal(bus.Res_Funct3);
    upd      = bus.Res_Valid & ready & legal;
    misp     = upd & (taken != bus.Res_Pred_Taken);
    br_cnt_d = br_cnt_q + CNT_WIDTH'(upd);
    mp_cnt_d = mp_cnt_q + CNT_WIDTH'(misp);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bus.Ready            = ready;
  assign bus.Pred_Taken       = ready & pred_cnt[1];
  assign bus.Branch_Un_Ctrl   = bus.Res_Funct3[1];
  assign bus.Branch_Taken     = taken;
  assign bus.Mispredict       = misp;
  assign bus.Branch_Count     = br_cnt_q;
  assign bus.Mispredict_Count = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_resolve;
  import branch_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_if #(.DWIDTH(DW), .CNT_WIDTH(CW)) bus ();

  branch_resolve #(
    .DWIDTH    (DW),
    .BHT_DEPTH (DEPTH),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef enum int {SG_READY, SG_PRED, SG_TAKEN, SG_UN, SG_MISP, SG_BCNT, SG_MCNT} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    int unsigned exp;
  } chk_t;

  chk_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_sig(input string name, input sig_e sig, input int unsigned exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  function automatic int unsigned sample(input sig_e s);
    case (s)
      SG_READY: return 32'(bus.Ready);
      SG_PRED:  return 32'(bus.Pred_Taken);
      SG_TAKEN: return 32'(bus.Branch_Taken);
      SG_UN:    return 32'(bus.Branch_Un_Ctrl);
      SG_MISP:  return 32'(bus.Mispredict);
      SG_BCNT:  return 32'(bus.Branch_Count);
      SG_MCNT:  return 32'(bus.Mispredict_Count);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      int unsigned act;
      c   = sb.pop_front();
      act = sample(c.sig);
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", c.name, act, c.exp, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                     input logic pt, input logic eq, input logic lt);
    bus.Res_Valid      = v;
    bus.Res_PC         = pc;
    bus.Res_Funct3     = f3;
    bus.Res_Pred_Taken = pt;
    bus.Branch_Equal   = eq;
    bus.Branch_Lt      = lt;
  endtask

  // Drives the init window with a live branch; nothing may update until Ready.
  task automatic init_sweep();
    for (int i = 0; i <= DEPTH; i++) begin
      bus.Pred_PC = 32'(i % DEPTH) * 4;
      res(i < DEPTH, 32'h100, F3_BEQ, 1'b0, 1'b1, 1'b0);
      expect_sig("init_ready", SG_READY, (i == DEPTH) ? 1 : 0);
      expect_sig("init_pred", SG_PRED, 0);
      expect_sig("init_bcnt", SG_BCNT, 0);
      expect_sig("init_mcnt", SG_MCNT, 0);
      if (i < DEPTH) begin
        expect_sig("init_misp", SG_MISP, 0);
        expect_sig("init_taken", SG_TAKEN, 1);
      end
      step();
    end
    res(1'b0, 32'h0, F3_BEQ, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < DEPTH; j++) begin
      bus.Pred_PC = 32'(j) * 4;
      expect_sig("post_init_pred", SG_PRED, 0);
      step();
    end
  endtask

  task automatic dec(input logic [2:0] f3, input logic eq, input logic lt,
                     input int unsigned t, input int unsigned u);
    res(1'b0, 32'h20, f3, 1'b0, eq, lt);
    expect_sig("dec_taken", SG_TAKEN, t);
    expect_sig("dec_un", SG_UN, u);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Pred_PC = '0;
    res(1'b1, 32'h100, F3_BEQ, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      step();
      expect_sig("rst_ready", SG_READY, 0);
      expect_sig("rst_bcnt", SG_BCNT, 0);
      expect_sig("rst_mcnt", SG_MCNT, 0);
      expect_sig("rst_pred", SG_PRED, 0);
      expect_sig("rst_misp", SG_MISP, 0);
    end
    step();
    rst = 1'b0;
    init_sweep();

    // Outcome decode
    dec(F3_BLTU, 1'b0, 1'b1, 1, 1);
    dec(F3_BGE,  1'b0, 1'b1, 0, 0);
    dec(F3_BEQ,  1'b1, 1'b0, 1, 0);
    dec(F3_BNE,  1'b1, 1'b0, 0, 0);
    dec(F3_BLT,  1'b0, 1'b0, 0, 0);
    dec(F3_BGEU, 1'b0, 1'b0, 1, 1);

    // Illegal funct3 with valid high
    res(1'b1, 32'h20, 3'b010, 1'b1, 1'b1, 1'b1);
    expect_sig("ill010_taken", SG_TAKEN, 0);
    expect_sig("ill010_misp", SG_MISP, 0);
    step();
    res(1'b1, 32'h20, 3'b011, 1'b1, 1'b1, 1'b1);
    expect_sig("ill011_taken", SG_TAKEN, 0);
    expect_sig("ill011_misp", SG_MISP, 0);
    expect_sig("ill010_bcnt", SG_BCNT, 0);
    step();
    res(1'b0, 32'h20, F3_BEQ, 1'b0, 1'b0, 1'b0);
    expect_sig("ill011_bcnt", SG_BCNT, 0);
    step();

    // Training at 0x100: WNT -> WT -> ST -> ST, then down to SNT
    bus.Pred_PC = 32'h100;
    expect_sig("train_pred0", SG_PRED, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      res(1'b1, 32'h100, F3_BEQ, k > 0, 1'b1, 1'b0);
      expect_sig("train_t_pred", SG_PRED, (k > 0) ? 1 : 0);
      expect_sig("train_t_misp", SG_MISP, (k == 0) ? 1 : 0);
      expect_sig("train_t_bcnt", SG_BCNT, k);
      expect_sig("train_t_mcnt", SG_MCNT, (k > 0) ? 1 : 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      res(1'b1, 32'h100, F3_BEQ, k < 2, 1'b0, 1'b0);
      expect_sig("train_nt_pred", SG_PRED, (k < 2) ? 1 : 0);
      expect_sig("train_nt_misp", SG_MISP, (k < 2) ? 1 : 0);
      expect_sig("train_nt_bcnt", SG_BCNT, 3 + k);
      expect_sig("train_nt_mcnt", SG_MCNT, 1 + ((k < 2) ? k : 2));
      step();
    end
    res(1'b0, 32'h100, F3_BEQ, 1'b0, 1'b0, 1'b0);
    expect_sig("train_end_pred", SG_PRED, 0);
    expect_sig("train_end_bcnt", SG_BCNT, 7);
    expect_sig("train_end_mcnt", SG_MCNT, 3);
    step();

    // Same-cycle mispredict, counters on next edge
    res(1'b1, 32'h80, F3_BEQ, 1'b0, 1'b1, 1'b0);
    expect_sig("mp_misp", SG_MISP, 1);
    expect_sig("mp_taken", SG_TAKEN, 1);
    expect_sig("mp_un", SG_UN, 0);
    expect_sig("mp_bcnt_before", SG_BCNT, 7);
    expect_sig("mp_mcnt_before", SG_MCNT, 3);
    step();
    res(1'b0, 32'h80, F3_BEQ, 1'b0, 1'b1, 1'b0);
    expect_sig("mp_misp_idle", SG_MISP, 0);
    expect_sig("mp_bcnt_after", SG_BCNT, 8);
    expect_sig("mp_mcnt_after", SG_MCNT, 4);
    step();

    // Read-during-write on 0x40
    bus.Pred_PC = 32'h40;
    res(1'b1, 32'h40, F3_BEQ, 1'b0, 1'b1, 1'b0);
    expect_sig("rdw_pred_old", SG_PRED, 0);
    expect_sig("rdw_misp", SG_MISP, 1);
    step();
    res(1'b0, 32'h40, F3_BEQ, 1'b0, 1'b1, 1'b0);
    expect_sig("rdw_pred_new", SG_PRED, 1);
    expect_sig("rdw_bcnt", SG_BCNT, 9);
    expect_sig("rdw_mcnt", SG_MCNT, 5);
    step();

    // Counter wrap at 4 bits
    for (int k = 0; k < 7; k++) begin
      res(1'b1, 32'hC0, F3_BEQ, 1'b1, 1'b1, 1'b0);
      expect_sig("wrap_bcnt", SG_BCNT, 9 + k);
      expect_sig("wrap_misp", SG_MISP, 0);
      step();
    end
    res(1'b0, 32'hC0, F3_BEQ, 1'b0, 1'b0, 1'b0);
    expect_sig("wrap_bcnt_zero", SG_BCNT, 0);
    expect_sig("wrap_mcnt", SG_MCNT, 5);
    step();
    res(1'b1, 32'hC0, F3_BEQ, 1'b0, 1'b1, 1'b0);
    expect_sig("wrap_misp_last", SG_MISP, 1);
    step();

    // Reset mid-run
    res(1'b0, 32'hC0, F3_BEQ, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    expect_sig("mid_ready_before", SG_READY, 1);
    expect_sig("mid_bcnt_before", SG_BCNT, 1);
    expect_sig("mid_mcnt_before", SG_MCNT, 6);
    expect_sig("mid_pred_before", SG_PRED, 1);
    step();
    res(1'b1, 32'h100, F3_BEQ, 1'b0, 1'b1, 1'b0);
    expect_sig("mid_ready", SG_READY, 0);
    expect_sig("mid_bcnt", SG_BCNT, 0);
    expect_sig("mid_mcnt", SG_MCNT, 0);
    expect_sig("mid_pred", SG_PRED, 0);
    expect_sig("mid_misp", SG_MISP, 0);
    step();
    rst = 1'b0;
    init_sweep();

    step();
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Consumer and driver on the other side of the branch comparator interface.
- Drives Branch_Un_Ctrl into the comparator and takes Branch_Equal / Branch_Lt back. Combines them with funct3 to resolve the branch outcome.
- Holds a 2-bit saturating branch history table (BHT) that gives fetch a taken/not-taken prediction.
- Flags mispredictions and keeps branch and mispredict performance counters. Sits between decode/execute and PC-select logic.

Parameters:
- DWIDTH, 32, PC width.
- BHT_DEPTH, 64, number of BHT entries; power of two, at least 2.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- Clk  input  1  core clock.
- Reset  input  1  synchronous, active-high reset.
- Ready  output  1  high once BHT initialisation is complete.
- Pred_PC  input  DWIDTH  fetch PC to predict.
- Pred_Taken  output  1  prediction for Pred_PC.
- Res_Valid  input  1  a conditional branch is resolving this cycle.
- Res_PC  input  DWIDTH  PC of the resolving branch.
- Res_Funct3  input  3  funct3 of the resolving branch.
- Res_Pred_Taken  input  1  prediction originally issued for this branch.
- Branch_Un_Ctrl  output  1  unsigned-compare select, to the comparator.
- Branch_Equal  input  1  from the comparator.
- Branch_Lt  input  1  from the comparator.
- Branch_Taken  output  1  resolved outcome.
- Mispredict  output  1  resolved outcome differs from the prediction.
- Branch_Count  output  CNT_WIDTH  branches resolved since reset.
- Mispredict_Count  output  CNT_WIDTH  mispredictions since reset.

Behaviour:
- Index: IDX = PC[$clog2(BHT_DEPTH)+1:2], used for both Pred_PC and Res_PC.
- Branch_Un_Ctrl = Res_Funct3[1]; combinational, no dependence on state.
- Branch_Taken, combinational, driven regardless of state:
  - BEQ 000 = Equal; BNE 001 = !Equal.
  - BLT 100 = Lt; BGE 101 = !Lt.
  - BLTU 110 = Lt; BGEU 111 = !Lt.
  - 010 and 011 are illegal: Branch_Taken = 0.
- Legal update = Res_Valid & Ready & legal funct3.
- Mispredict = legal update & (Branch_Taken != Res_Pred_Taken). Combinational, so the pipeline can redirect in the same cycle.
- Pred_Taken = Ready & BHT[IDX(Pred_PC)][1]. Combinational read; returns 0 while not Ready.
- BHT counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- On a legal update, at the clock edge:
  - Taken increments the counter, saturating at 11.
  - Not taken decrements it, saturating at 00.
- Read-during-write to the same index: Pred_Taken reflects the old value; the new value is visible the next cycle.
- FSM, state S_INIT:
  - Entered on Reset; Init_Idx is cleared to 0 and Ready = 0.
  - Each cycle writes 01 to BHT[Init_Idx], then increments Init_Idx.
  - After the write to index BHT_DEPTH-1, moves to S_RUN.
  - Ready rises exactly BHT_DEPTH cycles after the first cycle with Reset low.
- FSM, state S_RUN: Ready = 1. Stays here until Reset.
- Res_Valid while not Ready: no BHT update, no counter increment, Mispredict = 0. Branch_Taken is still driven.
- Illegal funct3 with Res_Valid high: no BHT update, no counter increment, Mispredict = 0.
- Counters, registered:
  - Branch_Count increments by 1 on each legal update.
  - Mispredict_Count increments by 1 when Mispredict is high.
  - Both wrap modulo 2^CNT_WIDTH with no saturation.
- Reset while in S_RUN: at that edge, moves to S_INIT, clears Init_Idx, clears both counters, and drops Ready to 0. Table contents are rebuilt by the init sweep.
- Reset values: Ready 0, Branch_Count 0, Mispredict_Count 0, Pred_Taken 0, Mispredict 0.

Decomposition:
- Shared package branch_pkg holds:
  - funct3 constants F3_BEQ..F3_BGEU.
  - Enum bht_cnt_t {SNT, WNT, WT, ST}.
  - Enum br_state_t {S_INIT, S_RUN}.
  - Function sat_update(bht_cnt_t, logic taken).
- One sub-module, branch_hist_table: BHT storage plus the init sweep. It has one write port and one asynchronous read port. Outcome decode, mispredict logic and counters stay in branch_resolve.

Test Plan:
- Init: deassert Reset with BHT_DEPTH=64 → Ready goes high on cycle 64. Pred_Taken is 0 for every index, both before and after Ready.
- Decode: Res_Funct3 110 with Equal=0, Lt=1 → Branch_Un_Ctrl=1, Branch_Taken=1. Res_Funct3 101 with Lt=1 → Branch_Taken=0. Res_Funct3 010 → Branch_Taken=0, Branch_Count unchanged.
- Training: Res_PC=0x100 resolved taken 3 times → Pred_Taken(0x100) is 0 before, then 1 after the 1st update. Then 4 not-taken updates → 0 after the 2nd (counter walks 11→10→01), confirming saturation at 11.
- Mispredict: Res_Pred_Taken=0, BEQ, Equal=1 → Mispredict=1 in the same cycle. Mispredict_Count and Branch_Count each +1 on the next edge.
- Read-during-write: Pred_PC=Res_PC=0x40 and a taken update from WNT → Pred_Taken=0 that cycle, 1 the next cycle.
- Reset mid-run and wrap: with CNT_WIDTH=4, 16 legal updates → Branch_Count wraps to 0. Assert Reset mid-run → counters 0 and Ready 0 next cycle. Res_Valid during S_INIT leaves counters at 0.
